alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue-side controller that drives the 16-bit four-function ALU/writeback datapath: f0 function select, opcode destination select, two operands and carry/borrow-in. It accepts encoded instructions over a valid/ready handshake and reads operands from an internal 16x16 register file. It waits a fixed ALU latency, then captures the ALU result back into the destination register. This makes it the initiator and writeback consumer for the ALU; a host port preloads and inspects registers.

Parameters:
ALU_LAT, 1, cycles the ALU result is allowed to settle before capture (legal range 1..15)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept an instruction
instr_data  input  15  [14] carry/borrow-in, [13:12] func, [11:8] rd, [7:4] rs1, [3:0] rs2
alu_f0  output  2  function select to ALU mux (0 add, 1 sub, 2 mul, 3 div)
alu_opcode  output  4  writeback lane select; always equals latched rd
alu_inp1  output  16  operand A = reg[rs1]
alu_inp2  output  16  operand B = reg[rs2]
alu_cin  output  1  carry-in = instr_data[14]
alu_bin  output  1  borrow-in = instr_data[14]
alu_result  input  16  ALU mux output, sampled on the capture edge
done  output  1  one-cycle pulse when an instruction retires
err_div0  output  1  one-cycle pulse, coincident with done, for a divide-by-zero retire
host_we  input  1  host register write request
host_addr  input  4  host write/read register index
host_wdata  input  16  host write data
host_ack  output  1  combinational; high when host_we is accepted (host_we && state==IDLE)
host_rdata  output  16  combinational reg[host_addr]

Behaviour:
- Reset: state=IDLE, all 16 registers=0x0000, all alu_* outputs=0, done=0, err_div0=0, counter=0. instr_ready is combinational (state==IDLE), so it reads 1 out of reset.
- FSM states: IDLE and EXEC.
- IDLE: instr_ready=1. Accept happens on an edge where instr_valid=1.
  - On accept, register the func, rd, carry and operands reg[rs1] and reg[rs2] into the alu_* outputs.
  - Operands are read from the pre-edge register contents. rs1, rs2 and rd may alias.
  - If func==3 and reg[rs2]==0: no register write; done=1 and err_div0=1 next cycle; stay in IDLE.
  - Otherwise go to EXEC with counter=ALU_LAT-1.
- EXEC: instr_ready=0 and the alu_* outputs are held stable. The counter decrements each cycle.
  - On the edge where counter==0: reg[rd] <= alu_result, done <= 1, state <= IDLE.
- Timing: accept at edge k, capture at edge k+ALU_LAT, done high during cycle k+ALU_LAT.
  - instr_ready is high again in that same cycle, so sustained throughput is one instruction per ALU_LAT+1 cycles.
  - Back-to-back dependent instructions read the updated register because capture precedes the next accept.
- Width rule: the 16-bit alu_result is written as-is. Overflow, carry-out and mul upper bits are not tracked.
- Host port, writes:
  - Effective only when state==IDLE; host_ack reflects acceptance.
  - host_we during EXEC is ignored, with no queuing.
  - Host write and instruction accept on the same edge: the host write lands and operands see the pre-write value.
  - A host write to a register later captured as rd is overwritten by the writeback.
- Host port, reads: host_rdata is combinational and always available, including during EXEC.
- Reset asserted mid-EXEC: the operation is abandoned, no writeback, no done; the next cycle is IDLE with cleared registers.
- done and err_div0 are never high for more than one cycle per instruction.

Test Plan:
- Host preload r1=0x0005, r2=0x0003; ADD rd=3 rs1=1 rs2=2 carry=1 (ALU model) -> alu_f0=0, alu_opcode=3, alu_cin=1; r3=0x0009; done one cycle after ALU_LAT cycles.
- SUB rd=4 r1-r2, then MUL rd=5 r4*r4 back-to-back with instr_valid held high -> r4=0x0002, r5=0x0004; second accept occurs the cycle done pulses.
- DIV rd=6 rs1=1 rs2=7 with r7=0x0000 -> err_div0=done=1 next cycle; r6 stays 0x0000; instr_ready never drops.
- ALU_LAT=3: ADD issued, rst asserted on the 2nd EXEC cycle -> no done; next cycle instr_ready=1; all registers read 0x0000 via host_rdata.
- host_we to r9=0xBEEF during EXEC -> host_ack=0 and r9 unchanged. The same write in IDLE -> host_ack=1 and r9=0xBEEF.
- Alias case: r1=0x0007; ADD rd=1 rs1=1 rs2=1 carry=0 -> r1=0x000E; alu_inp1=alu_inp2=0x0007 held constant through EXEC.

Source files
------------

// File: rtl/alu_issue_if.sv
// Issue-side bus for alu_issue_ctrl: instruction handshake,
// ALU datapath drive/capture and host register access.
interface alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] instr_data;
  logic [1:0]  alu_f0;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_inp1;
  logic [15:0] alu_inp2;
  logic        alu_cin;
  logic        alu_bin;
  logic [15:0] alu_result;
  logic        done;
  logic        err_div0;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;

  modport master (
    output instr_valid, instr_data, alu_result,
    output host_we, host_addr, host_wdata,
    input  instr_ready, alu_f0, alu_opcode,
    input  alu_inp1, alu_inp2, alu_cin, alu_bin,
    input  done, err_div0, host_ack, host_rdata
  );

  modport slave (
    input  instr_valid, instr_data, alu_result,
    input  host_we, host_addr, host_wdata,
    output instr_ready, alu_f0, alu_opcode,
    output alu_inp1, alu_inp2, alu_cin, alu_bin,
    output done, err_div0, host_ack, host_rdata
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit four-function ALU: reads operands
// from a 16x16 register file, waits ALU_LAT cycles, writes back rd.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input logic       clk,
  input logic       rst,
  alu_issue_if.slave bus
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] rf [16];

  logic        i_c;
  logic [1:0]  i_f;
  logic [3:0]  i_rd;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        div0;

  assign i_c  = bus.instr_data[14];
  assign i_f  = bus.instr_data[13:12];
  assign i_rd = bus.instr_data[11:8];
  assign op_a = rf[bus.instr_data[7:4]];
  assign op_b = rf[bus.instr_data[3:0]];
  assign div0 = (i_f == 2'd3) && (op_b == 16'h0000);

  assign bus.instr_ready = (state == IDLE);
  assign bus.host_ack    = bus.host_we && (state == IDLE);
  assign bus.host_rdata  = rf[bus.host_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.done     <= 1'b0;
      bus.err_div0 <= 1'b0;
      bus.alu_f0     <= '0;
      bus.alu_opcode <= '0;
      bus.alu_inp1   <= '0;
      bus.alu_inp2   <= '0;
      bus.alu_cin    <= 1'b0;
      bus.alu_bin    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf[i] <= '0;
      end
    end else begin
      bus.done     <= 1'b0;
      bus.err_div0 <= 1'b0;
      // host_ack is only ever high in IDLE, so it never races writeback
      if (bus.host_ack) begin
        rf[bus.host_addr] <= bus.host_wdata;
      end
      unique case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            bus.alu_f0     <= i_f;
            bus.alu_opcode <= i_rd;
            bus.alu_inp1   <= op_a;
            bus.alu_inp2   <= op_b;
            bus.alu_cin    <= i_c;
            bus.alu_bin    <= i_c;
            if (div0) begin
              bus.done     <= 1'b1;
              bus.err_div0 <= 1'b1;
            end else begin
              state <= EXEC;
              cnt   <= LAT_M1;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rf[bus.alu_opcode] <= bus.alu_result;
            bus.done <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: ALU_LAT=1 instance checked
// through a retire monitor, ALU_LAT=3 instance for latency and reset.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst3;

  always #5 clk = ~clk;

  alu_issue_if b1();
  alu_issue_if b3();

  alu_issue_ctrl #(.ALU_LAT(1)) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  alu_issue_ctrl #(.ALU_LAT(3)) u3 (
    .clk(clk),
    .rst(rst3),
    .bus(b3.slave)
  );

  function automatic logic [15:0] alu_m(
    input logic [1:0] f, input logic [15:0] a,
    input logic [15:0] b, input logic c);
    logic [31:0] p;
    p = a * b;
    case (f)
      2'd0:    alu_m = a + b + {15'd0, c};
      2'd1:    alu_m = a - b - {15'd0, c};
      2'd2:    alu_m = p[15:0];
      default: alu_m = (b == 16'h0) ? 16'hFFFF : a / b;
    endcase
  endfunction

  assign b1.alu_result = alu_m(b1.alu_f0, b1.alu_inp1,
                               b1.alu_inp2, b1.alu_cin);
  assign b3.alu_result = alu_m(b3.alu_f0, b3.alu_inp1,
                               b3.alu_inp2, b3.alu_cin);

  typedef struct packed {
    logic [3:0]  rd;
    logic [1:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        err;
  } exp_t;

  exp_t sbq [$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(
    input logic [3:0] rd, input logic [1:0] f,
    input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] res, input logic c, input logic err);
    exp_t e;
    e.rd = rd; e.f = f; e.a = a; e.b = b;
    e.res = res; e.c = c; e.err = err;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Retire monitor for the ALU_LAT=1 instance
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && b1.err_div0 && !b1.done) begin
        checks++;
        errors++;
        $display("FAIL stray_err_div0 got 1 want 0 at %0t", $time);
      end
      if (!rst && b1.done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got 1 want 0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("ret_opcode", 16'(b1.alu_opcode), 16'(e.rd));
          chk("ret_f0", 16'(b1.alu_f0), 16'(e.f));
          chk("ret_inp1", b1.alu_inp1, e.a);
          chk("ret_inp2", b1.alu_inp2, e.b);
          chk("ret_cin", 16'(b1.alu_cin), 16'(e.c));
          chk("ret_bin", 16'(b1.alu_bin), 16'(e.c));
          chk("ret_err_div0", 16'(b1.err_div0), 16'(e.err));
          if (!e.err) chk("ret_result", b1.alu_result, e.res);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic hostw(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    b1.host_we = 1'b1; b1.host_addr = a; b1.host_wdata = d;
    #1 chk("host_ack_idle", 16'(b1.host_ack), 16'd1);
    @(posedge clk);
    #1 b1.host_we = 1'b0;
  endtask

  task automatic rd1(input logic [3:0] a, input logic [15:0] exp,
                     input string nm);
    @(negedge clk);
    b1.host_addr = a;
    #1 chk(nm, b1.host_rdata, exp);
  endtask

  task automatic send(input logic [14:0] d, input exp_t e);
    int n = 0;
    @(negedge clk);
    b1.instr_valid = 1'b1;
    b1.instr_data  = d;
    while (!b1.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b1.instr_ready) begin
      chk("accept_timeout", 16'(b1.instr_ready), 16'd1);
      b1.instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbq.push_back(e);
      #1 b1.instr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int lat, input string nm);
    int n = 0;
    while (!b1.done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, 16'(n), 16'(lat));
  endtask

  initial begin : stim
    int n;
    logic seen;
    rst = 1'b1; rst3 = 1'b1;
    b1.instr_valid = 1'b0; b1.instr_data = '0;
    b1.host_we = 1'b0; b1.host_addr = '0; b1.host_wdata = '0;
    b3.instr_valid = 1'b0; b3.instr_data = '0;
    b3.host_we = 1'b0; b3.host_addr = '0; b3.host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;

    @(negedge clk);
    chk("rst_ready", 16'(b1.instr_ready), 16'd1);
    chk("rst_done", 16'(b1.done), 16'd0);
    chk("rst_err", 16'(b1.err_div0), 16'd0);
    chk("rst_f0", 16'(b1.alu_f0), 16'd0);
    chk("rst_opcode", 16'(b1.alu_opcode), 16'd0);
    chk("rst_inp1", b1.alu_inp1, 16'd0);
    chk("rst_inp2", b1.alu_inp2, 16'd0);
    chk("rst_cin", 16'(b1.alu_cin), 16'd0);
    chk("rst_rdata", b1.host_rdata, 16'd0);

    // ADD r3 = r1 + r2 + 1
    hostw(4'd1, 16'h0005);
    hostw(4'd2, 16'h0003);
    send({1'b1, 2'd0, 4'd3, 4'd1, 4'd2},
         mk(4'd3, 2'd0, 16'h5, 16'h3, 16'h9, 1'b1, 1'b0));
    chk("add_ready_low", 16'(b1.instr_ready), 16'd0);
    wait_done(1, "add_latency");
    rd1(4'd3, 16'h0009, "r3_add");

    // SUB r4 = r1 - r2, then MUL r5 = r4 * r4 with valid held
    @(negedge clk);
    b1.instr_valid = 1'b1;
    b1.instr_data  = {1'b0, 2'd1, 4'd4, 4'd1, 4'd2};
    @(posedge clk);
    sbq.push_back(mk(4'd4, 2'd1, 16'h5, 16'h3, 16'h2, 1'b0, 1'b0));
    #1 b1.instr_data = {1'b0, 2'd2, 4'd5, 4'd4, 4'd4};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.instr_ready && n < 40);
    chk("b2b_accept_on_done", 16'(b1.done), 16'd1);
    @(posedge clk);
    sbq.push_back(mk(4'd5, 2'd2, 16'h2, 16'h2, 16'h4, 1'b0, 1'b0));
    #1 b1.instr_valid = 1'b0;
    wait_done(1, "mul_latency");
    rd1(4'd4, 16'h0002, "r4_sub");
    rd1(4'd5, 16'h0004, "r5_mul");

    // DIV by zero: r6 = r1 / r7, r7 == 0
    send({1'b0, 2'd3, 4'd6, 4'd1, 4'd7},
         mk(4'd6, 2'd3, 16'h5, 16'h0, 16'h0, 1'b0, 1'b1));
    chk("div0_ready", 16'(b1.instr_ready), 16'd1);
    wait_done(0, "div0_latency");
    @(posedge clk);
    #1 chk("div0_pulse_one", 16'(b1.done), 16'd0);
    rd1(4'd6, 16'h0000, "r6_div0");

    // host write during EXEC is dropped
    send({1'b0, 2'd0, 4'd8, 4'd1, 4'd2},
         mk(4'd8, 2'd0, 16'h5, 16'h3, 16'h8, 1'b0, 1'b0));
    b1.host_we = 1'b1; b1.host_addr = 4'd9; b1.host_wdata = 16'hBEEF;
    #1 chk("host_ack_exec", 16'(b1.host_ack), 16'd0);
    @(posedge clk);
    #1 b1.host_we = 1'b0;
    chk("exec_done", 16'(b1.done), 16'd1);
    rd1(4'd9, 16'h0000, "r9_ignored");
    hostw(4'd9, 16'hBEEF);
    rd1(4'd9, 16'hBEEF, "r9_written");
    rd1(4'd8, 16'h0008, "r8_add");

    // host write and accept on the same edge: operands are pre-write
    @(negedge clk);
    b1.host_we = 1'b1; b1.host_addr = 4'd10; b1.host_wdata = 16'h1234;
    b1.instr_valid = 1'b1;
    b1.instr_data  = {1'b0, 2'd0, 4'd11, 4'd10, 4'd10};
    @(posedge clk);
    sbq.push_back(mk(4'd11, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0));
    #1 b1.host_we = 1'b0; b1.instr_valid = 1'b0;
    wait_done(1, "same_edge_latency");
    rd1(4'd10, 16'h1234, "r10_host");
    rd1(4'd11, 16'h0000, "r11_prewrite");

    // alias: r1 = r1 + r1
    hostw(4'd1, 16'h0007);
    send({1'b0, 2'd0, 4'd1, 4'd1, 4'd1},
         mk(4'd1, 2'd0, 16'h7, 16'h7, 16'hE, 1'b0, 1'b0));
    chk("alias_inp1", b1.alu_inp1, 16'h0007);
    chk("alias_inp2", b1.alu_inp2, 16'h0007);
    wait_done(1, "alias_latency");
    rd1(4'd1, 16'h000E, "r1_alias");

    // ALU_LAT=3 instance: latency, then reset mid-EXEC
    @(negedge clk);
    b3.host_we = 1'b1; b3.host_addr = 4'd1; b3.host_wdata = 16'h0011;
    @(posedge clk);
    #1 b3.host_we = 1'b0;
    @(negedge clk);
    b3.instr_valid = 1'b1;
    b3.instr_data  = {1'b1, 2'd0, 4'd3, 4'd1, 4'd1};
    @(posedge clk);
    #1 b3.instr_valid = 1'b0;
    n = 0;
    while (!b3.done && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("lat3_latency", 16'(n), 16'd3);
    b3.host_addr = 4'd3;
    #1 chk("lat3_r3", b3.host_rdata, 16'h0023);

    @(negedge clk);
    b3.instr_valid = 1'b1;
    b3.instr_data  = {1'b0, 2'd0, 4'd2, 4'd1, 4'd1};
    @(posedge clk);
    #1 b3.instr_valid = 1'b0;
    chk("lat3_exec_ready", 16'(b3.instr_ready), 16'd0);
    @(posedge clk);
    #1 rst3 = 1'b1;
    @(posedge clk);
    #1 rst3 = 1'b0;
    chk("rst_mid_ready", 16'(b3.instr_ready), 16'd1);
    chk("rst_mid_done", 16'(b3.done), 16'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (b3.done) seen = 1'b1;
    end
    chk("rst_mid_no_done", 16'(seen), 16'd0);
    for (int i = 0; i < 16; i++) begin
      b3.host_addr = 4'(i);
      #1 chk("rst_mid_reg", b3.host_rdata, 16'h0000);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(sbq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
